// File: rtl/snake_engine.sv
// Snake game-state engine: movement, wall/self collisions, growth and LFSR food placement.
// Only MAX_LEN body slots are stored; slots at or beyond the current length read back as the food cell.
module snake_engine #(
  parameter int MAX_LEN  = 8,
  parameter int INIT_LEN = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              tick,
  input  logic [1:0]        dir,
  output logic [255:0][7:0] pos,
  output logic [7:0]        length,
  output logic [7:0]        foodPos,
  output logic [7:0]        score,
  output logic              game_over,
  output logic              win
);
  typedef enum logic [1:0] {IDLE, RUN, PLACE, OVER} state_e;

  localparam logic [1:0] HEAD_RIGHT = 2'd1;
  localparam logic [7:0] FOOD_INIT  = 8'h4A;
  localparam logic [7:0] LFSR_SEED  = 8'h5A;

  state_e                  state_q, state_d;
  logic [MAX_LEN-1:0][7:0] body_q, body_d;
  logic [1:0]              heading_q, heading_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              food_q, food_d;
  logic [7:0]              score_q, score_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic                    win_q, win_d;

  logic [7:0] lfsrNext, head, nh, lenInc;
  logic [1:0] newHeading;
  logic       wallHit, eat, selfHit, occupied;
  int         collLimit;

  function automatic logic [MAX_LEN-1:0][7:0] initBody();
    logic [MAX_LEN-1:0][7:0] b;
    for (int k = 0; k < MAX_LEN; k++) b[k] = 8'(32'h44 - k);
    return b;
  endfunction

  always_comb begin
    lfsrNext   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    head       = body_q[0];
    newHeading = (dir == (heading_q ^ 2'd2)) ? heading_q : dir;
    nh         = head;
    wallHit    = 1'b0;
    case (newHeading)
      2'd0:    begin nh = head - 8'd16; wallHit = (head[7:4] == 4'd0);  end
      2'd1:    begin nh = head + 8'd1;  wallHit = (head[3:0] == 4'd15); end
      2'd2:    begin nh = head + 8'd16; wallHit = (head[7:4] == 4'd15); end
      default: begin nh = head - 8'd1;  wallHit = (head[3:0] == 4'd0);  end
    endcase
    eat = (nh == food_q);
    // The tail slot vacates on a plain move, so it only blocks the head when growing.
    collLimit = eat ? int'(len_q) : int'(len_q) - 1;
    selfHit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++)
      if (k < collLimit && body_q[k] == nh) selfHit = 1'b1;
    occupied = 1'b0;
    for (int k = 0; k < MAX_LEN; k++)
      if (k < int'(len_q) && body_q[k] == lfsrNext) occupied = 1'b1;
    lenInc = len_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    body_d    = body_q;
    heading_d = heading_q;
    len_d     = len_q;
    food_d    = food_q;
    score_d   = score_q;
    lfsr_d    = lfsr_q;
    win_d     = win_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (!start && tick) begin
          lfsr_d    = lfsrNext;
          heading_d = newHeading;
          if (wallHit || selfHit) begin
            state_d = OVER;
          end else begin
            body_d[0] = nh;
            for (int k = 1; k < MAX_LEN; k++) body_d[k] = body_q[k-1];
            if (eat) begin
              len_d   = lenInc;
              score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              if (int'(lenInc) == MAX_LEN) begin
                state_d = OVER;
                win_d   = 1'b1;
              end else begin
                state_d = PLACE;
              end
            end
          end
        end
      end
      PLACE: begin
        lfsr_d = lfsrNext;
        if (!occupied) begin
          food_d  = lfsrNext;
          state_d = RUN;
        end
      end
      default: begin
        if (start) begin
          body_d    = initBody();
          heading_d = HEAD_RIGHT;
          len_d     = 8'(INIT_LEN);
          food_d    = FOOD_INIT;
          score_d   = 8'd0;
          win_d     = 1'b0;
          state_d   = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      body_q    <= initBody();
      heading_q <= HEAD_RIGHT;
      len_q     <= 8'(INIT_LEN);
      food_q    <= FOOD_INIT;
      score_q   <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      body_q    <= body_d;
      heading_q <= heading_d;
      len_q     <= len_d;
      food_q    <= food_d;
      score_q   <= score_d;
      lfsr_q    <= lfsr_d;
      win_q     <= win_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 256; k++) pos[k] = food_q;
    for (int k = 0; k < MAX_LEN; k++)
      if (k < int'(len_q)) pos[k] = body_q[k];
  end

  assign length    = len_q;
  assign foodPos   = food_q;
  assign score     = score_q;
  assign game_over = (state_q == OVER);
  assign win       = win_q;
endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: three instances (default, INIT_LEN=5, MAX_LEN=4) share stimulus.
// Expected head cells are queued when a tick is driven and popped once the DUT has updated.
module tb_snake_engine;
  logic       clk = 1'b0;
  logic       reset_n, start, tick;
  logic [1:0] dir;

  logic [255:0][7:0] posA, posB, posC;
  logic [7:0] lenA, lenB, lenC, foodA, foodB, foodC, scoreA, scoreB, scoreC;
  logic       overA, overB, overC, winA, winB, winC;

  int total = 0;
  int bad   = 0;
  logic [7:0] expQ[$];

  snake_engine dutA (.clk(clk), .reset_n(reset_n), .start(start), .tick(tick), .dir(dir),
    .pos(posA), .length(lenA), .foodPos(foodA), .score(scoreA), .game_over(overA), .win(winA));
  snake_engine #(.MAX_LEN(8), .INIT_LEN(5)) dutB (.clk(clk), .reset_n(reset_n), .start(start),
    .tick(tick), .dir(dir), .pos(posB), .length(lenB), .foodPos(foodB), .score(scoreB),
    .game_over(overB), .win(winB));
  snake_engine #(.MAX_LEN(4), .INIT_LEN(3)) dutC (.clk(clk), .reset_n(reset_n), .start(start),
    .tick(tick), .dir(dir), .pos(posC), .length(lenC), .foodPos(foodC), .score(scoreC),
    .game_over(overC), .win(winC));

  always #5 clk = ~clk;

  task doReset();
    reset_n = 1'b0; start = 1'b0; tick = 1'b0; dir = 2'd1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task moveTick(input logic [1:0] d, input logic [7:0] expHead);
    @(negedge clk); dir = d; tick = 1'b1;
    expQ.push_back(expHead);
    @(negedge clk); tick = 1'b0;
  endtask

  task test_reset();
    logic [7:0] exp;
    doReset();
    total++; if (posA[0] !== 8'h44 || posA[1] !== 8'h43 || posA[2] !== 8'h42) begin bad++;
      $display("FAIL reset_body got=%h %h %h want=44 43 42", posA[0], posA[1], posA[2]); end
    total++; if (posA[3] !== 8'h4A || foodA !== 8'h4A) begin bad++;
      $display("FAIL reset_food got pos3=%h food=%h want=4a", posA[3], foodA); end
    total++; if (lenA !== 8'd3 || scoreA !== 8'd0 || overA !== 1'b0 || winA !== 1'b0) begin bad++;
      $display("FAIL reset_flags got len=%0d score=%0d over=%b win=%b", lenA, scoreA, overA, winA); end
    moveTick(2'd1, 8'h44);
    exp = expQ.pop_front();
    total++; if (posA[0] !== exp) begin bad++;
      $display("FAIL idle_tick head got=%h want=%h", posA[0], exp); end
  endtask

  task test_basic_move();
    logic [7:0] exp;
    doReset(); pulseStart();
    for (int i = 0; i < 3; i++) begin
      moveTick(2'd1, 8'(8'h45 + i));
      exp = expQ.pop_front();
      total++; if (posA[0] !== exp) begin bad++;
        $display("FAIL move%0d head got=%h want=%h", i, posA[0], exp); end
    end
    total++; if (posA[1] !== 8'h46 || posA[2] !== 8'h45 || posA[3] !== 8'h4A || lenA !== 8'd3) begin bad++;
      $display("FAIL move_body got=%h %h %h len=%0d want=46 45 4a len=3", posA[1], posA[2], posA[3], lenA); end
  endtask

  task test_reverse();
    logic [7:0] exp;
    doReset(); pulseStart();
    moveTick(2'd3, 8'h45);
    exp = expQ.pop_front();
    total++; if (posA[0] !== exp) begin bad++;
      $display("FAIL reverse head got=%h want=%h", posA[0], exp); end
  endtask

  task test_wall();
    logic [7:0] exp;
    logic [7:0] heads [5];
    heads = '{8'h34, 8'h24, 8'h14, 8'h04, 8'h04};
    doReset(); pulseStart();
    for (int i = 0; i < 5; i++) begin
      moveTick(2'd0, heads[i]);
      exp = expQ.pop_front();
      total++; if (posA[0] !== exp) begin bad++;
        $display("FAIL wall_step%0d head got=%h want=%h", i, posA[0], exp); end
    end
    total++; if (overA !== 1'b1 || winA !== 1'b0 || lenA !== 8'd3) begin bad++;
      $display("FAIL wall_over got over=%b win=%b len=%0d want 1 0 3", overA, winA, lenA); end
    moveTick(2'd1, 8'h04);
    exp = expQ.pop_front();
    total++; if (posA[0] !== exp) begin bad++;
      $display("FAIL over_tick head got=%h want=%h", posA[0], exp); end
  endtask

  task test_eat();
    logic [7:0] exp;
    int waited, hits, stale;
    doReset(); pulseStart();
    for (int i = 0; i < 6; i++) begin
      moveTick(2'd1, 8'(8'h45 + i));
      exp = expQ.pop_front();
      total++; if (posA[0] !== exp) begin bad++;
        $display("FAIL eat_step%0d head got=%h want=%h", i, posA[0], exp); end
    end
    total++; if (lenA !== 8'd4 || scoreA !== 8'd1 || posA[3] !== 8'h47) begin bad++;
      $display("FAIL eat_grow got len=%0d score=%0d pos3=%h want 4 1 47", lenA, scoreA, posA[3]); end
    waited = 0;
    while (foodA == 8'h4A && waited < 600) begin @(negedge clk); waited++; end
    total++; if (foodA === 8'h4A) begin bad++;
      $display("FAIL place_timeout food got=%h want new cell", foodA); end
    hits = 0; stale = 0;
    for (int k = 0; k < 4; k++) if (posA[k] === foodA) hits++;
    for (int k = 4; k < 256; k++) if (posA[k] !== foodA) stale++;
    total++; if (foodA === 8'h00 || hits != 0) begin bad++;
      $display("FAIL place_free got food=%h body_hits=%0d want nonzero free cell", foodA, hits); end
    total++; if (stale != 0) begin bad++;
      $display("FAIL unused_slots got %0d slots differ from food want 0", stale); end
  endtask

  task test_self_collision();
    logic [7:0] exp;
    logic [1:0] dirs [3];
    logic [7:0] heads [3];
    dirs  = '{2'd2, 2'd3, 2'd0};
    heads = '{8'h54, 8'h53, 8'h53};
    doReset(); pulseStart();
    for (int i = 0; i < 3; i++) begin
      moveTick(dirs[i], heads[i]);
      exp = expQ.pop_front();
      total++; if (posB[0] !== exp) begin bad++;
        $display("FAIL self_step%0d head got=%h want=%h", i, posB[0], exp); end
      if (i == 1) begin
        total++; if (posB[1] !== 8'h54 || posB[2] !== 8'h44 || posB[3] !== 8'h43 || posB[4] !== 8'h42) begin bad++;
          $display("FAIL self_body got=%h %h %h %h want=54 44 43 42", posB[1], posB[2], posB[3], posB[4]); end
      end
    end
    total++; if (overB !== 1'b1 || winB !== 1'b0 || lenB !== 8'd5) begin bad++;
      $display("FAIL self_over got over=%b win=%b len=%0d want 1 0 5", overB, winB, lenB); end
  endtask

  task test_win_restart();
    logic [7:0] exp;
    doReset(); pulseStart();
    for (int i = 0; i < 6; i++) begin
      moveTick(2'd1, 8'(8'h45 + i));
      exp = expQ.pop_front();
    end
    total++; if (posC[0] !== exp || overC !== 1'b1 || winC !== 1'b1 || lenC !== 8'd4 || scoreC !== 8'd1) begin bad++;
      $display("FAIL win got head=%h over=%b win=%b len=%0d score=%0d want %h 1 1 4 1", posC[0], overC, winC, lenC, scoreC, exp); end
    pulseStart();
    total++; if (posC[0] !== 8'h44 || posC[2] !== 8'h42 || lenC !== 8'd3 || foodC !== 8'h4A) begin bad++;
      $display("FAIL restart_body got head=%h p2=%h len=%0d food=%h want 44 42 3 4a", posC[0], posC[2], lenC, foodC); end
    total++; if (scoreC !== 8'd0 || overC !== 1'b0 || winC !== 1'b0) begin bad++;
      $display("FAIL restart_flags got score=%0d over=%b win=%b want 0 0 0", scoreC, overC, winC); end
    moveTick(2'd1, 8'h45);
    exp = expQ.pop_front();
    total++; if (posC[0] !== exp) begin bad++;
      $display("FAIL restart_run head got=%h want=%h", posC[0], exp); end
  endtask

  task test_back_to_back();
    logic [7:0] exp;
    doReset();
    @(negedge clk); start = 1'b1; tick = 1'b1; dir = 2'd1;
    expQ.push_back(8'h44);
    @(negedge clk); start = 1'b0; tick = 1'b0;
    exp = expQ.pop_front();
    total++; if (posA[0] !== exp) begin bad++;
      $display("FAIL start_tick head got=%h want=%h", posA[0], exp); end
    moveTick(2'd1, 8'h45);
    exp = expQ.pop_front();
    total++; if (posA[0] !== exp) begin bad++;
      $display("FAIL after_start head got=%h want=%h", posA[0], exp); end
  endtask

  task test_reset_mid_place();
    logic [7:0] exp;
    doReset(); pulseStart();
    for (int i = 0; i < 6; i++) begin
      moveTick(2'd1, 8'(8'h45 + i));
      exp = expQ.pop_front();
    end
    reset_n = 1'b0;
    #1;
    total++; if (posA[0] !== 8'h44 || lenA !== 8'd3 || scoreA !== 8'd0 || foodA !== 8'h4A) begin bad++;
      $display("FAIL mid_place_reset got head=%h len=%0d score=%0d food=%h want 44 3 0 4a", posA[0], lenA, scoreA, foodA); end
    @(negedge clk); reset_n = 1'b1;
    moveTick(2'd1, 8'h44);
    exp = expQ.pop_front();
    total++; if (posA[0] !== exp) begin bad++;
      $display("FAIL post_reset_idle head got=%h want=%h", posA[0], exp); end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_reverse();
    test_wall();
    test_eat();
    test_self_collision();
    test_win_restart();
    test_back_to_back();
    test_reset_mid_place();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_engine.md
# snake_engine

Game-state engine for the snake game. It advances the snake one cell per move tick, applies the player's direction, detects wall and self collisions, handles eating and growth, and places new food with an LFSR. Its `pos`/`length`/`foodPos` outputs drive the grid-conversion stage, which renders the 16x16 display grid.

## Interface
- `MAX_LEN`, default 8: maximum snake length. Legal range 4..255. Reaching it is a win.
- `INIT_LEN`, default 3: length at reset and restart. Legal range 2..5, and less than `MAX_LEN`.
- `clk` input, 1 bit: system clock. All state changes on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: one-cycle pulse. Begins play from IDLE, or restarts from OVER.
- `tick` input, 1 bit: one-cycle move strobe.
- `dir` input, 2 bits: requested heading, sampled only on `tick`. 0 = up, 1 = right, 2 = down, 3 = left.
- `pos` output, [255:0][7:0]: cell indices, `row*16 + col`. `pos[0]` is the head.
- `length` output, 8 bits: current snake length.
- `foodPos` output, 8 bits: food cell index.
- `score` output, 8 bits: foods eaten. Saturates at 255.
- `game_over` output, 1 bit: high while in OVER.
- `win` output, 1 bit: high in OVER when the game ended by reaching `MAX_LEN`.

## Operation
- **Reset / initial snake** (also applied on restart):
  - `pos[k] = 0x44 - k` for k < `INIT_LEN`.
  - heading = right, `foodPos = 0x4A`, `length = INIT_LEN`, `score = 0`, `game_over = win = 0`, state IDLE.
- **Unused slots:** every `pos[k]` with k ≥ `length` (including 8..255) equals `foodPos` at all times. The downstream stage clears cells for unused slots before drawing food, so no body cell is ever erased.
- **LFSR:** 8 bits, polynomial x^8+x^6+x^5+x^4+1, seeded 0x5A by `reset_n` only; restart does not reseed. It advances only on a tick accepted in RUN and on each PLACE cycle. It is never 0, so cell 0x00 is never chosen as food.
- **States:**
  - **IDLE:** wait for `start` → RUN. `tick` is ignored.
  - **RUN:** on `tick`:
    - Heading becomes `dir`, unless `dir` is the exact reverse of the current heading; then the current heading is kept.
    - Next head `nh` = head −16 / +1 / +16 / −1 for up / right / down / left.
    - **Wall:** moving up at row 0, down at row 15, left at col 0, or right at col 15 → OVER. `pos` and `length` are unchanged.
    - **Eat:** `nh == foodPos`.
    - **Self collision:** `nh` matches `pos[k]`. Compare k in 1..`length`−1 when eating; k in 1..`length`−2 when not eating, because the tail vacates. A match → OVER, `pos` unchanged.
    - **Otherwise:** shift `pos[k] <= pos[k-1]` for k ≥ 1, then `pos[0] <= nh`.
    - **If eating:** `length` +1, `score` +1.
      - If the new `length == MAX_LEN` → OVER with `win = 1`.
      - Else → PLACE.
  - **PLACE:** each cycle, advance the LFSR; the candidate is the new LFSR value.
    - If the candidate matches no `pos[k]` with k < `length`: `foodPos <=` candidate, and unused slots are updated in the same edge; → RUN.
    - Otherwise stay in PLACE. The next cycle retries.
    - `tick` is dropped in PLACE.
  - **OVER:** outputs hold. `start` → reinitialize the snake → RUN directly. `tick` is ignored.

## Timing
- All outputs are registered and update on the edge that samples `tick` or `start`, i.e. one cycle after the strobe.
- PLACE lasts ≥ 1 cycle. The bound is the number of LFSR steps to a free cell. The system guarantees tick spacing ≥ 512 cycles.
- `start` and `tick` in the same cycle: `start` wins and the tick is discarded.
- `reset_n` low at any time, including mid-PLACE: all state takes reset values immediately. Operation resumes on the first edge after release.

## Test plan
- **Basic move:** reset, `start`, 3 ticks with `dir = 1` → `pos[0..2]` = 0x47, 0x46, 0x45; `length = 3`; `pos[3] = 0x4A`.
- **Reverse ignored:** after start, tick with `dir = 3` → head 0x45 (moves right).
- **Wall:** after start, ticks with `dir = 0` → head 0x34, 0x24, 0x14, 0x04. The 5th tick → `game_over = 1`, head stays 0x04, `win = 0`.
- **Eat:** after start, 6 ticks right → head 0x4A, `length = 4`, `score = 1`. After PLACE: `foodPos` ≠ 0, not in `pos[0..3]`, and `pos[4..255] == foodPos`.
- **Self collision** (`INIT_LEN = 5`): ticks down, left, up → after 2 ticks `pos[0..4]` = 0x53, 0x54, 0x44, 0x43, 0x42. The 3rd tick → `game_over = 1`.
- **Win and restart:**
  - With `MAX_LEN = 4`, eat once → `game_over = win = 1`, `length = 4`.
  - `start` → initial snake, `score = 0`, state RUN.
  - `reset_n` pulse mid-PLACE → IDLE with reset values.
